// File: rtl/k2_pkg.sv
// K2 control unit shared definitions.
// State encoding, instruction field positions and destination codes.
package k2_pkg;

   localparam int IW_DEF = 8;
   localparam int JW_DEF = 3;

   localparam int J_BIT    = 7;
   localparam int C_BIT    = 6;
   localparam int DEST_MSB = 5;
   localparam int DEST_LSB = 4;
   localparam int SRC_BIT  = 3;
   localparam int IMM_MSB  = 2;
   localparam int IMM_LSB  = 0;

   localparam logic [1:0] DEST_RA   = 2'b00;
   localparam logic [1:0] DEST_RB   = 2'b01;
   localparam logic [1:0] DEST_RO   = 2'b10;
   localparam logic [1:0] DEST_NONE = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_HALT,
      S_FAULT
   } state_e;

endpackage

// File: rtl/k2_instr_decoder.sv
// K2 instruction decoder: pure combinational view of the IR.
// ld_o bit 0 = RA, bit 1 = RB, bit 2 = RO.
module k2_instr_decoder
   import k2_pkg::*;
#(
   parameter int IW = IW_DEF,
   parameter int JW = JW_DEF
) (
   input  logic [IW-1:0] ir_i,
   input  logic          carry_flag_i,
   output logic          is_halt_o,
   output logic          take_jump_o,
   output logic [2:0]    ld_o,
   output logic          src_sel_o,
   output logic [JW-1:0] imm_o,
   output logic [JW-1:0] tgt_o
);

   logic [1:0] dest;

   assign dest  = ir_i[DEST_MSB:DEST_LSB];
   assign tgt_o = ir_i[IMM_LSB +: JW];

   always_comb begin
      is_halt_o   = 1'b0;
      take_jump_o = 1'b0;
      ld_o        = 3'b000;
      src_sel_o   = 1'b0;
      imm_o       = '0;
      if (ir_i[J_BIT]) begin
         // Conditional jumps fall through to a step when carry is clear.
         take_jump_o = ~ir_i[C_BIT] | carry_flag_i;
      end else if (ir_i[C_BIT]) begin
         is_halt_o = 1'b1;
      end else begin
         unique case (dest)
            DEST_RA:   ld_o = 3'b001;
            DEST_RB:   ld_o = 3'b010;
            DEST_RO:   ld_o = 3'b100;
            DEST_NONE: ld_o = 3'b000;
            default:   ld_o = 3'b000;
         endcase
         src_sel_o = ir_i[SRC_BIT];
         imm_o     = ir_i[IMM_LSB +: JW];
      end
   end

endmodule

// File: rtl/k2_control_unit.sv
// K2 multi-cycle sequencer: fetch over req/ack, decode, execute.
// Owns the FSM, fetch wait counter, IR and carry flag.
module k2_control_unit
   import k2_pkg::*;
#(
   parameter int IW      = IW_DEF,
   parameter int JW      = JW_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   output logic          rom_req,
   input  logic          rom_ack,
   input  logic [IW-1:0] rom_data,
   input  logic          carry_in,
   output logic          pc_step,
   output logic          pc_jump,
   output logic [JW-1:0] pc_jump_imm,
   output logic          ld_ra,
   output logic          ld_rb,
   output logic          ld_ro,
   output logic          src_sel,
   output logic [JW-1:0] imm,
   output logic          carry_flag,
   output logic          busy,
   output logic          halted,
   output logic          fault
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [IW-1:0] ir_q, ir_d;
   logic          cf_q, cf_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          dec_halt;
   logic          dec_jump;
   logic [2:0]    dec_ld;
   logic          dec_src;
   logic [JW-1:0] dec_imm;
   logic [JW-1:0] dec_tgt;

   k2_instr_decoder #(
      .IW (IW),
      .JW (JW)
   ) u_dec (
      .ir_i         (ir_q),
      .carry_flag_i (cf_q),
      .is_halt_o    (dec_halt),
      .take_jump_o  (dec_jump),
      .ld_o         (dec_ld),
      .src_sel_o    (dec_src),
      .imm_o        (dec_imm),
      .tgt_o        (dec_tgt)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         cf_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cf_q    <= cf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign carry_flag = cf_q;

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      cf_d        = cf_q;
      cnt_d       = '0;
      rom_req     = 1'b0;
      pc_step     = 1'b0;
      pc_jump     = 1'b0;
      pc_jump_imm = '0;
      ld_ra       = 1'b0;
      ld_rb       = 1'b0;
      ld_ro       = 1'b0;
      src_sel     = 1'b0;
      imm         = '0;
      busy        = 1'b0;
      halted      = 1'b0;
      fault       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            rom_req = 1'b1;
            busy    = 1'b1;
            // An ack in the last allowed cycle still beats the timeout.
            if (rom_ack) begin
               ir_d    = rom_data;
               state_d = S_DECODE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DECODE: begin
            busy    = 1'b1;
            state_d = dec_halt ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            busy    = 1'b1;
            pc_jump = dec_jump;
            pc_step = ~dec_jump;
            if (dec_jump) pc_jump_imm = dec_tgt;
            {ld_ro, ld_rb, ld_ra} = dec_ld;
            src_sel = dec_src;
            imm     = dec_imm;
            if ((|dec_ld) && !dec_src) cf_d = carry_in;
            state_d = run ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         S_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
